channel_sim_sequencer: RTL

Run controller for the flash channel-model pipeline (program → RTN → buffer → CCI → P→S → retention). It owns the pipeline's dedicated reset and its symbol input. It issues a pseudo-random stream of 2-bit cell levels for a configured number of word lines, then counts the retention-stage outputs as they return. With the optional BER feature it also hard-decides each returned voltage and counts level errors. It sits above the channel top and is the only driver of its `VoltageLevel` input.

---
 rtl/channel_seq_pkg.sv | 38 +++
 rtl/chseq_sym_fifo.sv | 65 ++++++
 rtl/channel_sim_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/channel_seq_pkg.sv
// Shared types and constants for the channel-model run sequencer:
// FSM states, default read thresholds, symbol-LFSR taps and hard-decision helper.
package channel_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHRST,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } chseq_state_e;

    localparam int unsigned CELLS_PER_WL  = 16;
    localparam int unsigned CHRST_CYCLES  = 2;

    localparam logic [15:0] DEF_RD_T1     = 16'h2000;
    localparam logic [15:0] DEF_RD_T2     = 16'h5000;
    localparam logic [15:0] DEF_RD_T3     = 16'h8000;
    localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

    // Galois form of x^16+x^14+x^13+x^11+1, right-shifting
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ({1'b0, s[15:1]} ^ LFSR_TAPS) : {1'b0, s[15:1]};
    endfunction

    function automatic logic [1:0] hard_decide(input logic [15:0] v,
                                               input logic [15:0] t1,
                                               input logic [15:0] t2,
                                               input logic [15:0] t3);
        if (v < t1)      return 2'd0;
        else if (v < t2) return 2'd1;
        else if (v < t3) return 2'd2;
        else             return 2'd3;
    endfunction

endpackage

// File: rtl/chseq_sym_fifo.sv
// Expected-symbol FIFO for the run sequencer: synchronous, power-of-2 depth,
// simultaneous push/pop allowed (a push while full succeeds if a pop happens too).
module chseq_sym_fifo #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned  AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]  FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign dout_o  = mem_q[rptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/channel_sim_sequencer.sv
// Run controller for the flash channel-model pipeline: resets the channel, issues
// LFSR cell levels, counts returns. Define CHSEQ_BER_EN to add level-error checking.
module channel_sim_sequencer
    import channel_seq_pkg::*;
#(
    parameter int unsigned NUM_WL      = 64,
    parameter int unsigned FIFO_DEPTH  = 256,
    parameter logic [15:0] RD_T1       = DEF_RD_T1,
    parameter logic [15:0] RD_T2       = DEF_RD_T2,
    parameter logic [15:0] RD_T3       = DEF_RD_T3,
    parameter logic [15:0] LFSR_SEED   = DEF_LFSR_SEED,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        chan_reset,
    output logic [1:0]  VoltageLevel,
    input  logic        RetentionDoneFlag,
    input  logic [15:0] VoltageOutAfterRetention,
    output logic [31:0] cells_out,
    output logic [31:0] err_cnt,
    output logic        fifo_ovf,
    output logic        fifo_udf
);

    localparam logic [31:0] NCELLS    = 32'(NUM_WL * CELLS_PER_WL);
    localparam logic [31:0] WDOG_LIM  = 32'(TIMEOUT_CYC);
    localparam logic [31:0] CHRST_END = 32'(CHRST_CYCLES - 1);

    chseq_state_e state_q, state_d;
    logic [31:0]  cnt_q, cnt_d;
    logic [31:0]  wdog_q, wdog_d;
    logic [31:0]  cells_q, cells_d;
    logic [15:0]  lfsr_q, lfsr_d;
    logic [1:0]   vl_q, vl_d;
    logic         busy_q, busy_d, done_q, done_d, tmo_q, tmo_d, crst_q, crst_d;
    logic         accept, rx_cnt, push, wdog_exp;

    assign accept   = (state_q == ST_IDLE) && start;
    assign rx_cnt   = RetentionDoneFlag && (cells_q < NCELLS)
                   && (state_q inside {ST_ISSUE, ST_DRAIN, ST_DONE});
    // Watchdog holds cycles elapsed since the last counted receive; expire as it reaches the limit
    assign wdog_exp = (state_q == ST_DRAIN) && !rx_cnt && (wdog_q >= WDOG_LIM - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_CHRST;
            ST_CHRST: if (cnt_q == CHRST_END) state_d = ST_ISSUE;
            ST_ISSUE: if (cnt_q == NCELLS - 1) state_d = ST_DRAIN;
            ST_DRAIN: if (cells_q == NCELLS || wdog_exp) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        push   = (state_d == ST_ISSUE);
        busy_d = state_d inside {ST_CHRST, ST_ISSUE, ST_DRAIN};
        done_d = (state_d == ST_DONE);
        crst_d = (state_d != ST_CHRST);
        vl_d   = push ? lfsr_q[1:0] : 2'b00;

        lfsr_d = lfsr_q;
        if (accept)    lfsr_d = LFSR_SEED;
        else if (push) lfsr_d = lfsr_step(lfsr_q);

        cnt_d = cnt_q;
        if (accept || (state_q != state_d)) cnt_d = '0;
        else if (state_q inside {ST_CHRST, ST_ISSUE}) cnt_d = cnt_q + 1'b1;

        cells_d = cells_q;
        if (accept)      cells_d = '0;
        else if (rx_cnt) cells_d = cells_q + 1'b1;

        wdog_d = wdog_q;
        if (accept)      wdog_d = '0;
        else if (rx_cnt) wdog_d = 32'd1;
        else if ((state_q inside {ST_CHRST, ST_ISSUE, ST_DRAIN}) && wdog_q < WDOG_LIM)
            wdog_d = wdog_q + 1'b1;

        tmo_d = tmo_q;
        if (accept) tmo_d = 1'b0;
        else if (state_q == ST_DRAIN && state_d == ST_DONE && cells_q != NCELLS) tmo_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            wdog_q  <= '0;
            cells_q <= '0;
            lfsr_q  <= LFSR_SEED;
            vl_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            crst_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            wdog_q  <= wdog_d;
            cells_q <= cells_d;
            lfsr_q  <= lfsr_d;
            vl_q    <= vl_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            crst_q  <= crst_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign timeout      = tmo_q;
    assign chan_reset   = crst_q;
    assign VoltageLevel = vl_q;
    assign cells_out    = cells_q;

`ifdef CHSEQ_BER_EN
    logic        fifo_full, fifo_empty;
    logic [1:0]  fifo_head, rx_level;
    logic [31:0] err_q, err_d;
    logic        ovf_q, ovf_d, udf_q, udf_d;

    chseq_sym_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2)
    ) u_sym_fifo (
        .clk_i   (clk),
        .rst_n_i (reset),
        .clr_i   (accept),
        .push_i  (push),
        .din_i   (lfsr_q[1:0]),
        .pop_i   (rx_cnt),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        rx_level = hard_decide(VoltageOutAfterRetention, RD_T1, RD_T2, RD_T3);
        err_d    = err_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (accept) begin
            err_d = '0;
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else begin
            if (push && fifo_full && !rx_cnt) ovf_d = 1'b1;
            if (rx_cnt && fifo_empty)         udf_d = 1'b1;
            if (rx_cnt && !fifo_empty && rx_level != fifo_head && err_q != '1)
                err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            err_q <= err_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign err_cnt  = err_q;
    assign fifo_ovf = ovf_q;
    assign fifo_udf = udf_q;
`else
    logic unused_ber;
    assign unused_ber = ^{VoltageOutAfterRetention, RD_T1, RD_T2, RD_T3, FIFO_DEPTH};

    assign err_cnt  = '0;
    assign fifo_ovf = 1'b0;
    assign fifo_udf = 1'b0;
`endif

endmodule
